// File: rtl/rr_arbiter_n.sv
// -----------------------------------------------------------------------------
// rr_arbiter_n
//
// N-requester arbiter with a registered one-hot grant and grant lock. The
// current owner keeps the grant for as long as its request stays high. When
// the owner drops its request, arbitration over the remaining requests happens
// on that same edge, so there is no dead cycle. Arbitration is either
// round-robin (PRIO_MODE=0) or fixed priority with the highest index winning
// (PRIO_MODE=1).
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, an owner that has held the grant for MAX_HOLD cycles loses
//   it on the next edge if any other requester is waiting. A sole requester
//   keeps the grant indefinitely.
//
// Parameters:
//   N         number of requesters (>=2)
//   PRIO_MODE 0 = round-robin, 1 = fixed priority (highest index wins)
//   MAX_HOLD  max consecutive grant cycles per owner (ARB_TIMEOUT_EN only, >=2)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-high
//   req          request vector, bit i = requester i
//   grant        registered one-hot grant, all-zero when idle
//   grant_id     index of the granted requester, 0 when idle
//   grant_valid  high whenever any grant is active
// -----------------------------------------------------------------------------
module rr_arbiter_n #(
    parameter int N         = 4,
    parameter int PRIO_MODE = 0,
    parameter int MAX_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_valid
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [IW-1:0]   owner, owner_next;
    logic [IW-1:0]   ptr, ptr_next;
    logic [N-1:0]    owner_mask;
    logic [N-1:0]    arb_req;
    logic            force_release;
    logic            hold;
    logic            found;
    logic [IW-1:0]   win;

    assign owner_mask = {{(N-1){1'b0}}, 1'b1} << owner;

    // The owner keeps the grant unless it dropped its request or it is
    // being pushed out by the hold timeout.
    assign hold = (state == OWNED) && req[owner] && !force_release;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    logic [CW-1:0] hold_cnt, hold_cnt_next;

    // Only another waiting requester can force a release; a lone owner
    // sits at the saturated count and keeps the grant.
    assign force_release = (state == OWNED) && (hold_cnt == HOLD_LAST) &&
                           (|(req & ~owner_mask));

    always_comb begin
        hold_cnt_next = '0;
        if (hold) begin
            hold_cnt_next = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_next;
        end
    end
`else
    assign force_release = 1'b0;
`endif

    // Winner selection. On a forced release the owner is masked out; in
    // round-robin mode the pointer already sits past the owner, so the
    // scan naturally prefers the other requesters.
    always_comb begin
        int idx;
        arb_req = force_release ? (req & ~owner_mask) : req;
        found   = 1'b0;
        win     = '0;
        idx     = 0;
        if (PRIO_MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                idx = (int'(ptr) + i) % N;
                if (!found && arb_req[idx]) begin
                    found = 1'b1;
                    win   = IW'(idx);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (arb_req[i]) begin
                    found = 1'b1;
                    win   = IW'(i);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        ptr_next   = ptr;
        if (!hold) begin
            if (found) begin
                state_next = OWNED;
                owner_next = win;
                if (PRIO_MODE == 0) begin
                    ptr_next = IW'((int'(win) + 1) % N);
                end
            end else begin
                state_next = IDLE;
                owner_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            ptr   <= ptr_next;
        end
    end

    // Outputs decode straight from the registered owner, so req never
    // reaches grant combinationally.
    assign grant       = (state == OWNED) ? owner_mask : '0;
    assign grant_id    = (state == OWNED) ? owner : '0;
    assign grant_valid = (state == OWNED);

endmodule

// File: tb/tb_rr_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_n
//
// Self-checking bench for rr_arbiter_n with N=4. Two instances share clock and
// reset: one round-robin, one fixed-priority. Directed vectors with
// hand-computed expected grants. Timeout scenarios are compiled in when
// ARB_TIMEOUT_EN is defined, the lock scenario when it is not.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req_rr = 4'b0000;
    logic [3:0] req_fp = 4'b0000;

    logic [3:0] grant_rr, grant_fp;
    logic [1:0] grant_id_rr, grant_id_fp;
    logic       grant_valid_rr, grant_valid_fp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
    } vec_t;

    vec_t rr_tab[11];

    always #5 clk = ~clk;

    rr_arbiter_n #(.N(4), .PRIO_MODE(0), .MAX_HOLD(8)) dut_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (req_rr),
        .grant       (grant_rr),
        .grant_id    (grant_id_rr),
        .grant_valid (grant_valid_rr)
    );

    rr_arbiter_n #(.N(4), .PRIO_MODE(1), .MAX_HOLD(8)) dut_fp (
        .clk         (clk),
        .rst         (rst),
        .req         (req_fp),
        .grant       (grant_fp),
        .grant_id    (grant_id_fp),
        .grant_valid (grant_valid_fp)
    );

    // Drive new requests away from the edge, then sample 1 time unit after it.
    task automatic apply_stimulus(input logic [3:0] r_rr, input logic [3:0] r_fp);
        @(negedge clk);
        req_rr = r_rr;
        req_fp = r_fp;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input bit fp,
                                input logic [3:0] exp_grant, input logic [1:0] exp_id);
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        g  = fp ? grant_fp : grant_rr;
        id = fp ? grant_id_fp : grant_id_rr;
        v  = fp ? grant_valid_fp : grant_valid_rr;
        checks++;
        if (g !== exp_grant) begin
            errors++;
            $display("[TB] FAIL %s grant: got %b expected %b", name, g, exp_grant);
        end
        checks++;
        if (id !== exp_id) begin
            errors++;
            $display("[TB] FAIL %s grant_id: got %0d expected %0d", name, id, exp_id);
        end
        checks++;
        if (v !== (|exp_grant)) begin
            errors++;
            $display("[TB] FAIL %s grant_valid: got %b expected %b", name, v, |exp_grant);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        req_rr = 4'b0000;
        req_fp = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] eg;

        rr_tab[0]  = '{4'b0000, 4'b0000, 2'd0};
        rr_tab[1]  = '{4'b0110, 4'b0010, 2'd1};
        rr_tab[2]  = '{4'b0110, 4'b0010, 2'd1};
        rr_tab[3]  = '{4'b0100, 4'b0100, 2'd2};
        rr_tab[4]  = '{4'b1111, 4'b0100, 2'd2};
        rr_tab[5]  = '{4'b1011, 4'b1000, 2'd3};
        rr_tab[6]  = '{4'b0111, 4'b0001, 2'd0};
        rr_tab[7]  = '{4'b0000, 4'b0000, 2'd0};
        rr_tab[8]  = '{4'b0101, 4'b0100, 2'd2};
        rr_tab[9]  = '{4'b0001, 4'b0001, 2'd0};
        rr_tab[10] = '{4'b0000, 4'b0000, 2'd0};

        $display("[TB] reset with all requests high");
        req_rr = 4'b1111;
        req_fp = 4'b1111;
        #2 rst = 1'b1;
        #1;
        check_output("reset_async_rr", 1'b0, 4'b0000, 2'd0);
        check_output("reset_async_fp", 1'b1, 4'b0000, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_held_rr", 1'b0, 4'b0000, 2'd0);
        @(negedge clk);
        rst    = 1'b0;
        req_rr = 4'b0000;
        req_fp = 4'b0000;

        $display("[TB] round-robin vector table");
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(rr_tab[i].req, 4'b0000);
            check_output($sformatf("rr_tab%0d", i), 1'b0, rr_tab[i].grant, rr_tab[i].id);
        end

        $display("[TB] round-robin rotation without idle cycles");
        do_reset();
        apply_stimulus(4'b1111, 4'b0000);
        check_output("rot_first", 1'b0, 4'b0001, 2'd0);
        for (int k = 0; k < 4; k++) begin
            r  = ~(4'b0001 << k);
            eg = 4'b0001 << ((k + 1) % 4);
            apply_stimulus(r, 4'b0000);
            check_output($sformatf("rot%0d", k), 1'b0, eg, 2'((k + 1) % 4));
        end

        $display("[TB] asynchronous reset mid-grant");
        apply_stimulus(4'b0111, 4'b1111);
        check_output("pre_midrst_rr", 1'b0, 4'b0001, 2'd0);
        check_output("pre_midrst_fp", 1'b1, 4'b1000, 2'd3);
        #2 rst = 1'b1;
        #1;
        check_output("midrst_rr", 1'b0, 4'b0000, 2'd0);
        check_output("midrst_fp", 1'b1, 4'b0000, 2'd0);
        do_reset();

`ifndef ARB_TIMEOUT_EN
        $display("[TB] grant lock");
        apply_stimulus(4'b0011, 4'b0000);
        check_output("lock_first", 1'b0, 4'b0001, 2'd0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(4'b0011, 4'b0000);
            check_output($sformatf("lock_hold%0d", i), 1'b0, 4'b0001, 2'd0);
        end
        apply_stimulus(4'b0010, 4'b0000);
        check_output("lock_release", 1'b0, 4'b0010, 2'd1);
`else
        $display("[TB] hold timeout");
        for (int i = 0; i < 24; i++) begin
            eg = ((i / 8) % 2 == 0) ? 4'b0001 : 4'b0010;
            apply_stimulus(4'b0011, 4'b0011);
            check_output($sformatf("to_rr%0d", i), 1'b0, eg, (eg == 4'b0001) ? 2'd0 : 2'd1);
            eg = ((i / 8) % 2 == 0) ? 4'b0010 : 4'b0001;
            check_output($sformatf("to_fp%0d", i), 1'b1, eg, (eg == 4'b0001) ? 2'd0 : 2'd1);
        end
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(4'b0001, 4'b0001);
            check_output($sformatf("to_sole%0d", i), 1'b0, 4'b0001, 2'd0);
        end
`endif

        $display("[TB] fixed priority");
        do_reset();
        apply_stimulus(4'b0000, 4'b0011);
        check_output("fp_0011", 1'b1, 4'b0010, 2'd1);
        apply_stimulus(4'b0000, 4'b0001);
        check_output("fp_drop", 1'b1, 4'b0001, 2'd0);
        apply_stimulus(4'b0000, 4'b0000);
        check_output("fp_idle", 1'b1, 4'b0000, 2'd0);
        apply_stimulus(4'b0000, 4'b1111);
        check_output("fp_1111", 1'b1, 4'b1000, 2'd3);
        apply_stimulus(4'b0000, 4'b0111);
        check_output("fp_next", 1'b1, 4'b0100, 2'd2);

        $display("[TB] round-robin pointer wrap");
        do_reset();
        apply_stimulus(4'b0001, 4'b0000);
        check_output("wrap_g0", 1'b0, 4'b0001, 2'd0);
        apply_stimulus(4'b0000, 4'b0000);
        check_output("wrap_idle0", 1'b0, 4'b0000, 2'd0);
        apply_stimulus(4'b1000, 4'b0000);
        check_output("wrap_g3", 1'b0, 4'b1000, 2'd3);
        apply_stimulus(4'b0000, 4'b0000);
        check_output("wrap_idle1", 1'b0, 4'b0000, 2'd0);
        apply_stimulus(4'b1001, 4'b0000);
        check_output("wrap_ptr0", 1'b0, 4'b0001, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
